// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: two read addresses, one write port, registered read data
// and status flags.
interface regfile_param_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic        [ADDR_W-1:0] ReadReg1;
    logic        [ADDR_W-1:0] ReadReg2;
    logic        [ADDR_W-1:0] WAddr;
    logic signed [DATA_W-1:0] WData;
    logic                     RegWrite;
    logic signed [DATA_W-1:0] ReadData1;
    logic signed [DATA_W-1:0] ReadData2;
    logic                     Busy;
    logic                     WrReject;

    modport master (
        output ReadReg1, ReadReg2, WAddr, WData, RegWrite,
        input  ReadData1, ReadData2, Busy, WrReject
    );

    modport slave (
        input  ReadReg1, ReadReg2, WAddr, WData, RegWrite,
        output ReadData1, ReadData2, Busy, WrReject
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised 2R/1W register file with post-reset init sequencer and a write-protected window.
// Optional macro REGFILE_BYPASS_EN forwards accepted same-cycle writes to the read outputs.
module regfile_param #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned INIT_BASE = 100,
    parameter int unsigned SP_IDX    = 29,
    parameter int unsigned SP_INIT   = 1020,
    parameter int unsigned PROT_LO   = 26,
    parameter int unsigned PROT_HI   = 27
) (
    input logic            Clk,
    input logic            Reset,
    regfile_param_if.slave rf
);
    localparam int unsigned DEPTH     = 2 ** ADDR_W;
    localparam int unsigned ZERO_FROM = 28;

    if ((PROT_LO == 0) || ((SP_IDX >= PROT_LO) && (SP_IDX <= PROT_HI))) begin : g_bad_prot
        $error("regfile_param: protected window must not contain index 0 or SP_IDX");
    end

    typedef enum logic {StInit, StRun} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   regs_q [DEPTH];
    logic [DATA_W-1:0]   rd1_q, rd1_d, rd2_q, rd2_d;
    logic                wr_reject_q, wr_reject_d;
    logic                init_we;
    logic                accept;
    logic                waddr_prot;
    int unsigned         waddr_n;

    function automatic logic [DATA_W-1:0] init_value(input logic [ADDR_W-1:0] i);
        int unsigned n;
        n = 32'(i);
        if (n == 0)                          return '0;
        if (n == SP_IDX)                     return DATA_W'(SP_INIT);
        if ((n >= PROT_LO) && (n <= PROT_HI)) return '0;
        if (n >= ZERO_FROM)                  return '0;
        return DATA_W'(INIT_BASE + n);
    endfunction

    assign waddr_n    = 32'(rf.WAddr);
    assign waddr_prot = (waddr_n >= PROT_LO) && (waddr_n <= PROT_HI);
    assign accept     = (state_q == StRun) && rf.RegWrite && (rf.WAddr != '0) && !waddr_prot;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        init_we     = 1'b0;
        wr_reject_d = rf.RegWrite && !accept;
        unique case (state_q)
            StInit: begin
                init_we = 1'b1;
                idx_d   = idx_q + ADDR_W'(1);
                if (idx_q == ADDR_W'(DEPTH - 1)) state_d = StRun;
            end
            StRun: ;
            default: state_d = StInit;
        endcase
    end

    // Reads are zero during init; address 0 is forced to zero regardless of array content.
    always_comb begin
        rd1_d = '0;
        rd2_d = '0;
        if (state_q == StRun) begin
            if (rf.ReadReg1 != '0) rd1_d = regs_q[rf.ReadReg1];
            if (rf.ReadReg2 != '0) rd2_d = regs_q[rf.ReadReg2];
`ifdef REGFILE_BYPASS_EN
            if (accept && (rf.WAddr == rf.ReadReg1)) rd1_d = rf.WData;
            if (accept && (rf.WAddr == rf.ReadReg2)) rd2_d = rf.WData;
`endif
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= StInit;
            idx_q       <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            wr_reject_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            wr_reject_q <= wr_reject_d;
        end
    end

    // Array has no reset; while Reset is held the sequencer just rewrites index 0 with 0.
    always_ff @(posedge Clk) begin
        if (init_we) begin
            regs_q[idx_q] <= init_value(idx_q);
        end else if (accept) begin
            regs_q[rf.WAddr] <= rf.WData;
        end
    end

    assign rf.ReadData1 = rd1_q;
    assign rf.ReadData2 = rd2_q;
    assign rf.Busy      = (state_q == StInit);
    assign rf.WrReject  = wr_reject_q;
endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: scoreboard of expected read data and reject flags.
module tb_regfile_param;
    logic Clk = 1'b0;
    logic Reset;
    int   passed = 0;
    int   total  = 0;

    regfile_param_if #(.DATA_W(32), .ADDR_W(5)) rf ();

    regfile_param #(.DATA_W(32), .ADDR_W(5)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .rf    (rf)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic        rej;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [32];

    function automatic logic [31:0] init_val(input int i);
        if (i == 0)              return 32'd0;
        if (i == 29)             return 32'd1020;
        if (i == 26 || i == 27)  return 32'd0;
        if (i >= 28)             return 32'd0;
        return 32'(100 + i);
    endfunction

    task automatic model_init();
        for (int i = 0; i < 32; i++) model[i] = init_val(i);
    endtask

    // One RUN-mode cycle: drive, push expectation, advance to just after the edge.
    task automatic step(input logic [4:0] r1, input logic [4:0] r2, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        logic acc;
        rf.ReadReg1 = r1;
        rf.ReadReg2 = r2;
        rf.RegWrite = we;
        rf.WAddr    = wa;
        rf.WData    = wd;
        acc  = we && (wa != 5'd0) && !(wa == 5'd26 || wa == 5'd27);
        e.d1 = (r1 == 5'd0) ? 32'd0 : model[r1];
        e.d2 = (r2 == 5'd0) ? 32'd0 : model[r2];
`ifdef REGFILE_BYPASS_EN
        if (acc && wa == r1) e.d1 = wd;
        if (acc && wa == r2) e.d2 = wd;
`endif
        e.rej = we && !acc;
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
        rf.RegWrite = 1'b0;
        if (acc) model[wa] = wd;
    endtask

    task automatic wait_init(output int cnt);
        cnt = 0;
        while (rf.Busy === 1'b1 && cnt < 40) begin
            @(posedge Clk);
            #1;
            cnt++;
        end
    endtask

    task automatic test_reset();
        int cnt;
        exp_t e;
        logic [4:0] ra [3];
        logic [4:0] rb [3];
        ra = '{5'd0, 5'd25, 5'd29};
        rb = '{5'd4, 5'd26, 5'd31};
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        total++; if (rf.Busy !== 1'b1) $display("FAIL reset_busy got=%b want=1", rf.Busy);
        else passed++;
        total++; if (rf.ReadData1 !== 32'd0) $display("FAIL reset_rd1 got=%h want=0", rf.ReadData1);
        else passed++;
        total++; if (rf.ReadData2 !== 32'd0) $display("FAIL reset_rd2 got=%h want=0", rf.ReadData2);
        else passed++;
        total++; if (rf.WrReject !== 1'b0) $display("FAIL reset_rej got=%b want=0", rf.WrReject);
        else passed++;
        Reset = 1'b0;
        model_init();
        rf.ReadReg1 = 5'd4;
        wait_init(cnt);
        total++; if (cnt !== 32) $display("FAIL init_len got=%0d want=32", cnt);
        else passed++;
        total++; if (rf.ReadData1 !== 32'd0) $display("FAIL busy_read got=%h want=0", rf.ReadData1);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            step(ra[i], rb[i], 1'b0, 5'd0, 32'd0);
            e = exp_q.pop_front();
            total++;
            if (rf.ReadData1 !== e.d1)
                $display("FAIL init_rd1 addr=%0d got=%h want=%h", ra[i], rf.ReadData1, e.d1);
            else passed++;
            total++;
            if (rf.ReadData2 !== e.d2)
                $display("FAIL init_rd2 addr=%0d got=%h want=%h", rb[i], rf.ReadData2, e.d2);
            else passed++;
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        step(5'd0, 5'd0, 1'b1, 5'd8, 32'hFFFF_FFFB);
        e = exp_q.pop_front();
        total++; if (rf.WrReject !== e.rej) $display("FAIL wr8_rej got=%b want=%b", rf.WrReject, e.rej);
        else passed++;
        step(5'd8, 5'd8, 1'b0, 5'd0, 32'd0);
        e = exp_q.pop_front();
        total++; if (rf.ReadData1 !== 32'hFFFF_FFFB) $display("FAIL rd8_p1 got=%h want=fffffffb", rf.ReadData1);
        else passed++;
        total++; if (rf.ReadData2 !== e.d2) $display("FAIL rd8_p2 got=%h want=%h", rf.ReadData2, e.d2);
        else passed++;
    endtask

    task automatic test_reject();
        exp_t e;
        logic [4:0] wa [3];
        wa = '{5'd0, 5'd26, 5'd27};
        // Back-to-back drops keep WrReject high on every cycle.
        for (int i = 0; i < 3; i++) begin
            step(5'd0, 5'd0, 1'b1, wa[i], 32'h1234);
            e = exp_q.pop_front();
            total++;
            if (rf.WrReject !== e.rej)
                $display("FAIL rej addr=%0d got=%b want=%b", wa[i], rf.WrReject, e.rej);
            else passed++;
        end
        step(5'd26, 5'd27, 1'b0, 5'd0, 32'd0);
        e = exp_q.pop_front();
        total++; if (rf.WrReject !== e.rej) $display("FAIL rej_clear got=%b want=%b", rf.WrReject, e.rej);
        else passed++;
        total++; if (rf.ReadData1 !== e.d1) $display("FAIL prot26 got=%h want=%h", rf.ReadData1, e.d1);
        else passed++;
        total++; if (rf.ReadData2 !== e.d2) $display("FAIL prot27 got=%h want=%h", rf.ReadData2, e.d2);
        else passed++;
        step(5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        e = exp_q.pop_front();
        total++; if (rf.ReadData1 !== e.d1) $display("FAIL zero_reg got=%h want=%h", rf.ReadData1, e.d1);
        else passed++;
    endtask

    task automatic test_bypass();
        exp_t e;
        step(5'd9, 5'd9, 1'b1, 5'd9, 32'd77);
        e = exp_q.pop_front();
        total++; if (rf.ReadData1 !== e.d1) $display("FAIL byp_same_p1 got=%h want=%h", rf.ReadData1, e.d1);
        else passed++;
        total++; if (rf.ReadData2 !== e.d2) $display("FAIL byp_same_p2 got=%h want=%h", rf.ReadData2, e.d2);
        else passed++;
        step(5'd9, 5'd0, 1'b0, 5'd0, 32'd0);
        e = exp_q.pop_front();
        total++; if (rf.ReadData1 !== e.d1) $display("FAIL byp_next got=%h want=%h", rf.ReadData1, e.d1);
        else passed++;
    endtask

    task automatic test_busy_write();
        int cnt;
        exp_t e;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_init();
        @(posedge Clk);
        #1;
        rf.RegWrite = 1'b1;
        rf.WAddr    = 5'd5;
        rf.WData    = 32'd999;
        @(posedge Clk);
        #1;
        rf.RegWrite = 1'b0;
        total++; if (rf.WrReject !== 1'b1) $display("FAIL busy_rej got=%b want=1", rf.WrReject);
        else passed++;
        wait_init(cnt);
        total++; if (cnt !== 30) $display("FAIL busy_rest got=%0d want=30", cnt);
        else passed++;
        step(5'd5, 5'd5, 1'b0, 5'd0, 32'd0);
        e = exp_q.pop_front();
        total++; if (rf.ReadData1 !== e.d1) $display("FAIL busy_rd5 got=%h want=%h", rf.ReadData1, e.d1);
        else passed++;
    endtask

    task automatic test_reset_midway();
        int cnt;
        exp_t e;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        repeat (10) begin
            @(posedge Clk);
            #1;
        end
        Reset = 1'b1;
        #1;
        total++; if (rf.Busy !== 1'b1) $display("FAIL mid_init_busy got=%b want=1", rf.Busy);
        else passed++;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_init();
        wait_init(cnt);
        total++; if (cnt !== 32) $display("FAIL mid_init_len got=%0d want=32", cnt);
        else passed++;
        step(5'd0, 5'd0, 1'b1, 5'd3, 32'd0);
        void'(exp_q.pop_front());
        step(5'd3, 5'd0, 1'b0, 5'd0, 32'd0);
        e = exp_q.pop_front();
        total++; if (rf.ReadData1 !== e.d1) $display("FAIL run_rd3 got=%h want=%h", rf.ReadData1, e.d1);
        else passed++;
        rf.ReadReg1 = 5'd3;
        Reset = 1'b1;
        #1;
        total++; if (rf.Busy !== 1'b1) $display("FAIL mid_run_busy got=%b want=1", rf.Busy);
        else passed++;
        total++; if (rf.ReadData1 !== 32'd0) $display("FAIL mid_run_rd got=%h want=0", rf.ReadData1);
        else passed++;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_init();
        wait_init(cnt);
        total++; if (cnt !== 32) $display("FAIL mid_run_len got=%0d want=32", cnt);
        else passed++;
        step(5'd3, 5'd0, 1'b0, 5'd0, 32'd0);
        e = exp_q.pop_front();
        total++; if (rf.ReadData1 !== e.d1) $display("FAIL reinit_rd3 got=%h want=%h", rf.ReadData1, e.d1);
        else passed++;
    endtask

    initial begin
        Reset       = 1'b1;
        rf.ReadReg1 = '0;
        rf.ReadReg2 = '0;
        rf.WAddr    = '0;
        rf.WData    = '0;
        rf.RegWrite = 1'b0;
        test_reset();
        test_write_read();
        test_reject();
        test_bypass();
        test_busy_write();
        test_reset_midway();
        total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised two-read/one-write register file, successor to the fixed 32×32 CPU register file in the datapath's decode stage. It adds configurable width and depth, a hardware initialisation sequencer after reset, and a write-protected address window with a rejection flag. It also adds an optional same-cycle write-to-read bypass. It feeds operand latches for the execute stage and takes write-back from the final pipeline stage.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W
- INIT_BASE, 100, general registers initialise to INIT_BASE + index
- SP_IDX, 29, stack-pointer register index
- SP_INIT, 1020, stack-pointer initial value
- PROT_LO, 26, lowest write-protected index (inclusive)
- PROT_HI, 27, highest write-protected index (inclusive)
- Clk  in  1  clock, all state changes on rising edge
- Reset  in  1  asynchronous, active-high reset
- ReadReg1  in  ADDR_W  read port 1 address
- ReadReg2  in  ADDR_W  read port 2 address
- WAddr  in  ADDR_W  write address
- WData  in  DATA_W  write data (signed)
- RegWrite  in  1  write enable
- ReadData1  out  DATA_W  read port 1 data (signed, registered)
- ReadData2  out  DATA_W  read port 2 data (signed, registered)
- Busy  out  1  high while the init sequencer runs; writes ignored
- WrReject  out  1  one-cycle pulse: a write was dropped (protected, index 0, or Busy)

## Operation
- Two states: INIT, RUN. Reset forces INIT with sequencer index 0.
- INIT:
  - each rising edge writes Registers[idx], then idx increments.
  - Values written: idx 0 gets 0. SP_IDX gets SP_INIT. PROT_LO..PROT_HI and indices ≥ 28 other than SP_IDX get 0. Every other index gets INIT_BASE + idx, truncated to DATA_W.
  - When idx == DEPTH-1 is written, the next state is RUN.
- RUN: write occurs when RegWrite=1, WAddr≠0, and WAddr is outside [PROT_LO, PROT_HI].
- Dropped write: RegWrite=1 with WAddr=0, a protected WAddr, or Busy=1. It leaves the array unchanged and sets WrReject=1 for the following cycle.
- Reads:
  - ReadDataN is sampled on the rising edge.
  - Address 0 always reads 0.
  - While Busy, both outputs are 0.
- A parameter set whose protected window contains 0 or SP_IDX is illegal; the implementation flags it with an elaboration-time error.

## Timing
- Reset asserted: Busy=1, ReadData1=ReadData2=0, WrReject=0, idx=0, array contents undefined until INIT completes.
- Busy stays high for exactly DEPTH rising edges after Reset deasserts. It falls in the same edge that writes the last register.
- First accepted write: the cycle after Busy falls.
- Read latency: 1 cycle. Address presented before edge N produces data valid after edge N.
- Write latency: a write at edge N is visible to a read sampled at edge N+1. Same-edge behaviour depends on the macro below.
- Both read ports addressing the same register return identical data.
- Reset asserted mid-INIT or mid-RUN: immediate return to INIT, idx=0, outputs cleared as above. Any in-flight write is lost.
- WrReject is high for exactly one cycle per dropped write. Back-to-back drops hold it high.

## Configuration
- REGFILE_BYPASS_EN defined: if an accepted write targets an address read in the same cycle, that ReadDataN captures WData at the same edge. This applies only to writes that are accepted. Address 0 and protected addresses are never bypassed.
- Undefined: the same-cycle read returns the pre-write value, and the new value appears one cycle later.

## Test plan
- Reset, deassert, wait → Busy high for 32 cycles. Then reads show $0=0, $4=104, $25=125, $26=0, $29=1020, $31=0.
- In RUN, write $8=-5, then read $8 on both ports next cycle → ReadData1=ReadData2=-5 (0xFFFFFFFB).
- Writes to $0, $26, $27 with WData=0x1234 → WrReject pulses once per attempt, and the registers read 0 afterwards.
- Write $9=77 while reading $9 in the same cycle → 77 with REGFILE_BYPASS_EN defined. Without it, 109, then 77 the next cycle.
- RegWrite=1 to $5 during Busy → write dropped, WrReject pulses, and $5 reads 105 after INIT.
- Assert Reset at cycle 10 of INIT and again after writing $3=0 in RUN → Busy restarts for 32 cycles, and $3 reads 103 afterwards.
